// File: rtl/fifo_1ton_pkg.sv
// Shared sizing helpers for the 1-to-N packing FIFO.
// Counter widths depend on instance parameters, so they are computed from these functions.
package fifo_1ton_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // items-held counter width: 0..DEPTH*NSIZE
  function automatic int cw_of(input int depth, input int nsize);
    return clog2(depth * nsize + 1);
  endfunction

  // words-held counter width: 0..DEPTH
  function automatic int rw_of(input int depth);
    return clog2(depth + 1);
  endfunction

  // pack_cnt width, never narrower than one bit
  function automatic int pw_of(input int nsize);
    return (nsize > 1) ? clog2(nsize) : 1;
  endfunction

  function automatic int aw_of(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_1ton_packer.sv
// Collects narrow items into one wide word, first item in the MSB slice.
// Emits word_commit/word_data on the cycle a word completes or a partial word is flushed.
module fifo_1ton_packer
  import fifo_1ton_pkg::*;
#(
  parameter int               DSIZE     = 8,
  parameter int               NSIZE     = 4,
  parameter logic [DSIZE-1:0] DEF_VALUE = '0,
  parameter int               PW        = pw_of(NSIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_acc,
  input  logic [DSIZE-1:0]       wr_data,
  input  logic                   flush,
  input  logic                   room,
  output logic [PW-1:0]          pack_cnt,
  output logic                   word_commit,
  output logic [DSIZE*NSIZE-1:0] word_data
);

  localparam logic [PW-1:0] LAST = PW'(NSIZE - 1);

  logic [NSIZE-1:0][DSIZE-1:0] pack_q, pack_d;
  logic [NSIZE-1:0][DSIZE-1:0] word_s;
  logic [PW-1:0]               pack_cnt_q, pack_cnt_d;
  logic [PW:0]                 filled;
  logic                        fill_done, flush_ok;

  assign filled = {1'b0, pack_cnt_q} + {{PW{1'b0}}, wr_acc};

  // Slice s holds item number NSIZE-1-s; slices past the fill level read as pad.
  for (genvar s = 0; s < NSIZE; s++) begin : g_slice
    assign pack_d[s] = (wr_acc && pack_cnt_q == PW'(NSIZE - 1 - s)) ? wr_data : pack_q[s];
    assign word_s[s] = (int'(filled) > (NSIZE - 1 - s)) ? pack_d[s] : DEF_VALUE;
  end

  always_comb begin
    fill_done   = wr_acc && (pack_cnt_q == LAST);
    flush_ok    = flush && (pack_cnt_q != '0) && room;
    word_commit = fill_done || flush_ok;
    pack_cnt_d  = pack_cnt_q;
    if (word_commit)  pack_cnt_d = '0;
    else if (wr_acc)  pack_cnt_d = pack_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q     <= '0;
      pack_cnt_q <= '0;
    end else begin
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
    end
  end

  assign pack_cnt  = pack_cnt_q;
  assign word_data = word_s;

endmodule

// File: rtl/fifo_1ton.sv
// Width up-converter FIFO: DSIZE items in, DSIZE*NSIZE words out, DEPTH words of storage.
// Define FIFO_1TON_FLUSH_EN to add wr_flush, which commits a partially packed word.
module fifo_1ton
  import fifo_1ton_pkg::*;
#(
  parameter int               DSIZE     = 8,
  parameter int               NSIZE     = 4,
  parameter int               DEPTH     = 8,
  parameter int               ALMOST    = 2,
  parameter logic [DSIZE-1:0] DEF_VALUE = '0,
  localparam int              CW        = cw_of(DEPTH, NSIZE),
  localparam int              RW        = rw_of(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DSIZE-1:0]       wr_data,
  output logic                   wr_full,
  output logic                   wr_almost_full,
  output logic [CW-1:0]          wr_count,
`ifdef FIFO_1TON_FLUSH_EN
  input  logic                   wr_flush,
`endif
  input  logic                   rd_en,
  output logic [DSIZE*NSIZE-1:0] rd_data,
  output logic                   rd_empty,
  output logic                   rd_almost_empty,
  output logic [RW-1:0]          rd_count,
  output logic                   rd_vld
);

  localparam int WW = DSIZE * NSIZE;
  localparam int PW = pw_of(NSIZE);
  localparam int AW = aw_of(DEPTH);

  logic [WW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [RW-1:0] words_q, words_d;
  logic [WW-1:0] rd_data_q, rd_data_d;
  logic          rd_vld_q, rd_vld_d;

  logic [PW-1:0] pack_cnt;
  logic          word_commit;
  logic [WW-1:0] word_data;
  logic          wr_acc, rd_acc, room, flush_in;

`ifdef FIFO_1TON_FLUSH_EN
  assign flush_in = wr_flush;
`else
  assign flush_in = 1'b0;
`endif

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full only when the next item would complete a word with nowhere to put it.
  assign room     = (words_q != RW'(DEPTH));
  assign wr_full  = !room && (pack_cnt == PW'(NSIZE - 1));
  assign wr_acc   = wr_en && !wr_full;
  assign rd_acc   = rd_en && (words_q != '0);

  fifo_1ton_packer #(
    .DSIZE     (DSIZE),
    .NSIZE     (NSIZE),
    .DEF_VALUE (DEF_VALUE),
    .PW        (PW)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_acc      (wr_acc),
    .wr_data     (wr_data),
    .flush       (flush_in),
    .room        (room),
    .pack_cnt    (pack_cnt),
    .word_commit (word_commit),
    .word_data   (word_data)
  );

  always_comb begin
    words_d   = words_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = rd_acc;
    case ({word_commit, rd_acc})
      2'b10:   words_d = words_q + 1'b1;
      2'b01:   words_d = words_q - 1'b1;
      default: words_d = words_q;
    endcase
    if (word_commit) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_acc) begin
      rd_ptr_d  = ptr_inc(rd_ptr_q);
      rd_data_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= {NSIZE{DEF_VALUE}};
      rd_vld_q  <= 1'b0;
    end else begin
      words_q   <= words_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (word_commit) begin
      mem_q[wr_ptr_q] <= word_data;
    end
  end

  assign wr_count        = CW'(words_q) * CW'(NSIZE) + CW'(pack_cnt);
  assign wr_almost_full  = int'(wr_count) >= (DEPTH * NSIZE - ALMOST);
  assign rd_empty        = (words_q == '0);
  assign rd_almost_empty = int'(words_q) <= ALMOST;
  assign rd_count        = words_q;
  assign rd_data         = rd_data_q;
  assign rd_vld          = rd_vld_q;

endmodule

// File: tb/tb_fifo_1ton.sv
// Bench for fifo_1ton: directed scenarios then random traffic against a queue-based model.
module tb_fifo_1ton;

  localparam int DSIZE = 8, NSIZE = 4, DEPTH = 2, ALMOST = 2;
  localparam int WW = DSIZE * NSIZE;
`ifdef FIFO_1TON_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0, rd_en = 1'b0, wr_flush = 1'b0;
  logic [DSIZE-1:0] wr_data = '0;
  logic            wr_full, wr_almost_full, rd_empty, rd_almost_empty, rd_vld;
  logic [3:0]      wr_count;
  logic [1:0]      rd_count;
  logic [WW-1:0]   rd_data;

  always #5 clk = ~clk;

  fifo_1ton #(.DSIZE(DSIZE), .NSIZE(NSIZE), .DEPTH(DEPTH), .ALMOST(ALMOST), .DEF_VALUE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .wr_almost_full(wr_almost_full), .wr_count(wr_count),
`ifdef FIFO_1TON_FLUSH_EN
    .wr_flush(wr_flush),
`endif
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_almost_empty(rd_almost_empty), .rd_count(rd_count), .rd_vld(rd_vld)
  );

  // reference model: stored words, items awaiting packing, last popped word
  logic [WW-1:0]    mq[$];
  logic [DSIZE-1:0] items[$];
  logic [WW-1:0]    m_rd_data;
  logic             m_rd_vld;
  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] build_word();
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < NSIZE; k++)
      w = (w << DSIZE) | WW'((k < items.size()) ? items[k] : 8'h00);
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    items.delete();
    m_rd_data = '0;
    m_rd_vld  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int cnt;
    cnt = mq.size() * NSIZE + items.size();
    chk({tag, ".wr_full"}, 64'(wr_full), 64'(mq.size() == DEPTH && items.size() == NSIZE - 1));
    chk({tag, ".wr_count"}, 64'(wr_count), 64'(cnt));
    chk({tag, ".wr_almost_full"}, 64'(wr_almost_full), 64'(cnt >= DEPTH * NSIZE - ALMOST));
    chk({tag, ".rd_empty"}, 64'(rd_empty), 64'(mq.size() == 0));
    chk({tag, ".rd_count"}, 64'(rd_count), 64'(mq.size()));
    chk({tag, ".rd_almost_empty"}, 64'(rd_almost_empty), 64'(mq.size() <= ALMOST));
    chk({tag, ".rd_vld"}, 64'(rd_vld), 64'(m_rd_vld));
    chk({tag, ".rd_data"}, 64'(rd_data), 64'(m_rd_data));
  endtask

  // One clock: drive at negedge, advance model at posedge, check 1 time unit later.
  task automatic step(input string tag, input logic we, input logic [7:0] d,
                      input logic re, input logic fl);
    bit full, wacc, racc, flok;
    @(negedge clk);
    wr_en = we; wr_data = d; rd_en = re; wr_flush = fl;
    @(posedge clk);
    full = (mq.size() == DEPTH) && (items.size() == NSIZE - 1);
    wacc = we && !full;
    racc = re && (mq.size() != 0);
    flok = FLUSH_EN && fl && (items.size() > 0) && (mq.size() < DEPTH);
    m_rd_vld = racc;
    if (racc) m_rd_data = mq.pop_front();
    if (wacc) items.push_back(d);
    if (items.size() == NSIZE || (flok && items.size() > 0)) begin
      mq.push_back(build_word());
      items.delete();
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    wr_en = 0; rd_en = 0; wr_flush = 0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic packing order
    step("t1w", 1, 8'h11, 0, 0);
    step("t1w", 1, 8'h22, 0, 0);
    step("t1w", 1, 8'h33, 0, 0);
    step("t1w", 1, 8'h44, 0, 0);
    chk("t1.rd_count", 64'(rd_count), 64'd1);
    step("t1r", 0, 8'h00, 1, 0);
    chk("t1.rd_data", 64'(rd_data), 64'h11223344);
    chk("t1.rd_vld", 64'(rd_vld), 64'd1);

    // 3: pop while empty
    step("t3", 0, 8'h00, 1, 0);
    chk("t3.rd_data_hold", 64'(rd_data), 64'h11223344);

    // 2: fill to full, dropped write, pop, accepted write
    for (int i = 1; i <= 11; i++) step("t2w", 1, 8'(i), 0, 0);
    chk("t2.wr_count", 64'(wr_count), 64'd11);
    chk("t2.wr_full", 64'(wr_full), 64'd1);
    step("t2drop", 1, 8'hEE, 0, 0);
    chk("t2.drop_count", 64'(wr_count), 64'd11);
    step("t2pop", 0, 8'h00, 1, 0);
    chk("t2.pop_data", 64'(rd_data), 64'h01020304);
    step("t2w12", 1, 8'h0C, 0, 0);
    chk("t2.wr_count12", 64'(wr_count), 64'd8);
    step("t2d", 0, 8'h00, 1, 0);
    step("t2d", 0, 8'h00, 1, 0);
    chk("t2.last_word", 64'(rd_data), 64'h090A0B0C);

    // 4: completing write and pop in the same cycle
    for (int i = 0; i < 7; i++) step("t4w", 1, 8'(8'h50 + i), 0, 0);
    step("t4both", 1, 8'h57, 1, 0);
    chk("t4.rd_count", 64'(rd_count), 64'd1);
    chk("t4.rd_data", 64'(rd_data), 64'h50515253);

    // 5: asynchronous reset mid-pack
    do_reset("t5pre");
    step("t5w", 1, 8'h01, 0, 0);
    step("t5w", 1, 8'h02, 0, 0);
    do_reset("t5rst");
    step("t5w", 1, 8'hAA, 0, 0);
    step("t5w", 1, 8'hBB, 0, 0);
    step("t5w", 1, 8'hCC, 0, 0);
    step("t5w", 1, 8'hDD, 0, 0);
    step("t5r", 0, 8'h00, 1, 0);
    chk("t5.rd_data", 64'(rd_data), 64'hAABBCCDD);

    // 6: flush of a partial word
    step("t6w", 1, 8'hAA, 0, 0);
    step("t6w", 1, 8'hBB, 0, 0);
    step("t6fl", 0, 8'h00, 0, 1);
    step("t6r", 0, 8'h00, 1, 0);
    if (FLUSH_EN) chk("t6.flush_word", 64'(rd_data), 64'hAABB0000);
    else          chk("t6.wr_count", 64'(wr_count), 64'd2);

    // random traffic
    do_reset("rnd_rst");
    for (int i = 0; i < 600; i++)
      step("rnd", ($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 9) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
